// File: rtl/maze_pkg.sv
// Shared maze constants: playfield geometry, path/goal rectangles, game states,
// pixel palette indices and the 10-bit background colour constants.
// Rectangles are half-open: x0 <= px < x1, y0 <= py < y1.
package maze_pkg;

   localparam int          NUM_RECTS = 8;
   localparam logic [10:0] SCREEN_W  = 11'd640;
   localparam logic [10:0] SCREEN_H  = 11'd480;

   typedef struct packed {
      logic [9:0] x0;
      logic [9:0] x1;
      logic [9:0] y0;
      logic [9:0] y1;
   } rect_t;

   // Start room, vertical corridor down, horizontal run to the goal,
   // plus dead-end branches on both sides of the screen.
   localparam rect_t PATH_RECTS [NUM_RECTS] = '{
      '{10'd40,  10'd200, 10'd47,  10'd90 },
      '{10'd160, 10'd200, 10'd47,  10'd300},
      '{10'd160, 10'd400, 10'd260, 10'd300},
      '{10'd20,  10'd60,  10'd90,  10'd200},
      '{10'd20,  10'd120, 10'd200, 10'd240},
      '{10'd440, 10'd600, 10'd40,  10'd80 },
      '{10'd560, 10'd600, 10'd80,  10'd420},
      '{10'd240, 10'd600, 10'd380, 10'd420}
   };

   // Goal sits at the far end of the horizontal run and is also path.
   localparam rect_t GOAL_RECT = '{10'd360, 10'd400, 10'd260, 10'd300};

   localparam logic [1:0] ST_PLAY = 2'd0;
   localparam logic [1:0] ST_HIT  = 2'd1;
   localparam logic [1:0] ST_WIN  = 2'd2;
   localparam logic [1:0] ST_LOSE = 2'd3;

   // Palette index bits: [2] red, [1] green, [0] blue at full scale.
   localparam logic [2:0] IDX_WALL   = 3'd0;
   localparam logic [2:0] IDX_FLASH  = 3'd1;
   localparam logic [2:0] IDX_GOAL   = 3'd2;
   localparam logic [2:0] IDX_SQUARE = 3'd5;
   localparam logic [2:0] IDX_PATH   = 3'd7;

   localparam logic [9:0] BG_RED_10   = 10'h0E1;
   localparam logic [9:0] BG_GREEN_10 = 10'h2C2;
   localparam logic [9:0] BG_BLUE_10  = 10'h37A;

   function automatic logic in_rect(input logic [10:0] px, input logic [10:0] py,
                                    input rect_t r);
      return (px >= {1'b0, r.x0}) && (px < {1'b0, r.x1}) &&
             (py >= {1'b0, r.y0}) && (py < {1'b0, r.y1});
   endfunction

endpackage

// File: rtl/maze_path_hit.sv
// Combinational rectangle lookup for one point.
//   px_i, py_i : 11-bit point (wrapped negatives land above the screen size)
//   inside_o   : point is on screen and inside any path rectangle
//   goal_o     : point is on screen and inside the goal rectangle
module maze_path_hit
   import maze_pkg::*;
(
   input  logic [10:0] px_i,
   input  logic [10:0] py_i,
   output logic        inside_o,
   output logic        goal_o
);

   logic on_screen;

   always_comb begin
      on_screen = (px_i < SCREEN_W) && (py_i < SCREEN_H);
      inside_o  = 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
         if (in_rect(px_i, py_i, PATH_RECTS[i])) inside_o = 1'b1;
      end
      inside_o = inside_o & on_screen;
      goal_o   = on_screen & in_rect(px_i, py_i, GOAL_RECT);
   end

endmodule

// File: rtl/maze_game_core.sv
// Maze game engine: player square movement with per-corner wall collision,
// lives, hit/win/lose handling and registered pixel colour generation.
//   clk_i, reset_i        : pixel clock, synchronous active-high reset
//   x_i, y_i              : current pixel coordinate from the sync counter
//   move*_i, start_n_i    : debounced active-low buttons
//   red_o/green_o/blue_o  : registered pixel colour, one clock after x_i/y_i
//   lives_o, state_o      : remaining lives and game state
//
// state | meaning
// PLAY  | square moves on frame ticks, collisions cost a life
// HIT   | square flashes for FLASH_FRAMES ticks, then respawns at start
// WIN   | square reached the goal, frozen until start_n_i
// LOSE  | no lives left, frozen until start_n_i
module maze_game_core
   import maze_pkg::*;
#(
   parameter int unsigned COLOR_W      = 10,
   parameter int unsigned SQUARE_SIZE  = 15,
   parameter int unsigned STEP         = 1,
   parameter int unsigned START_X      = 55,
   parameter int unsigned START_Y      = 55,
   parameter int unsigned NUM_LIVES    = 3,
   parameter int unsigned FLASH_FRAMES = 32,
   parameter int unsigned TICK_LINE    = 481
)(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [9:0]         x_i,
   input  logic [9:0]         y_i,
   input  logic               moveup_i,
   input  logic               movedown_i,
   input  logic               moveright_i,
   input  logic               moveleft_i,
   input  logic               start_n_i,
   output logic [COLOR_W-1:0] red_o,
   output logic [COLOR_W-1:0] green_o,
   output logic [COLOR_W-1:0] blue_o,
   output logic [2:0]         lives_o,
   output logic [1:0]         state_o
);

   localparam int unsigned        FW         = $clog2(FLASH_FRAMES + 1);
   localparam logic [10:0]        STEP_W     = 11'(STEP);
   localparam logic [10:0]        SQ_M1      = 11'(SQUARE_SIZE - 1);
   localparam logic [9:0]         START_X_W  = 10'(START_X);
   localparam logic [9:0]         START_Y_W  = 10'(START_Y);
   localparam logic [2:0]         LIVES_INIT = 3'(NUM_LIVES);
   localparam logic [FW-1:0]      FLASH_INIT = FW'(FLASH_FRAMES);
   localparam logic [COLOR_W-1:0] ONES       = '1;
   // Background constants are defined at 10 bits and rescaled to COLOR_W.
   localparam logic [COLOR_W-1:0] BG_R = COLOR_W'((32'(BG_RED_10)   << COLOR_W) >> 10);
   localparam logic [COLOR_W-1:0] BG_G = COLOR_W'((32'(BG_GREEN_10) << COLOR_W) >> 10);
   localparam logic [COLOR_W-1:0] BG_B = COLOR_W'((32'(BG_BLUE_10)  << COLOR_W) >> 10);

   logic [9:0]         sx_q, sx_d, sy_q, sy_d;
   logic [2:0]         lives_q, lives_d;
   logic [1:0]         state_q, state_d;
   logic [FW-1:0]      flash_q, flash_d;
   logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

   logic        tick, move_req;
   logic [10:0] cx, cy, cx_far, cy_far;
   logic [3:0]  corner_in, corner_goal;
   logic        pix_in, pix_goal, square_on, show_sq;
   logic [10:0] xe, ye;
   logic [2:0]  idx;

   assign tick = (y_i == 10'(TICK_LINE)) && (x_i == 10'd0);

   // Candidate position in 11 bits so an upward/leftward step past 0 wraps
   // to a huge value that the lookup treats as off-screen.
   always_comb begin
      cx       = {1'b0, sx_q};
      cy       = {1'b0, sy_q};
      move_req = 1'b1;
      if (!moveup_i)         cy = cy - STEP_W;
      else if (!movedown_i)  cy = cy + STEP_W;
      else if (!moveright_i) cx = cx + STEP_W;
      else if (!moveleft_i)  cx = cx - STEP_W;
      else                   move_req = 1'b0;
   end

   assign cx_far = cx + SQ_M1;
   assign cy_far = cy + SQ_M1;

   maze_path_hit u_c0 (.px_i(cx),     .py_i(cy),     .inside_o(corner_in[0]), .goal_o(corner_goal[0]));
   maze_path_hit u_c1 (.px_i(cx_far), .py_i(cy),     .inside_o(corner_in[1]), .goal_o(corner_goal[1]));
   maze_path_hit u_c2 (.px_i(cx),     .py_i(cy_far), .inside_o(corner_in[2]), .goal_o(corner_goal[2]));
   maze_path_hit u_c3 (.px_i(cx_far), .py_i(cy_far), .inside_o(corner_in[3]), .goal_o(corner_goal[3]));

   always_comb begin
      sx_d    = sx_q;
      sy_d    = sy_q;
      lives_d = lives_q;
      state_d = state_q;
      flash_d = flash_q;
      case (state_q)
         ST_PLAY: begin
            if (tick && move_req) begin
               if (&corner_in) begin
                  sx_d = cx[9:0];
                  sy_d = cy[9:0];
                  if (|corner_goal) state_d = ST_WIN;
               end else begin
                  lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                  flash_d = FLASH_INIT;
                  state_d = (lives_q <= 3'd1) ? ST_LOSE : ST_HIT;
               end
            end
         end
         ST_HIT: begin
            if (tick) begin
               if (flash_q <= FW'(1)) begin
                  flash_d = '0;
                  sx_d    = START_X_W;
                  sy_d    = START_Y_W;
                  state_d = ST_PLAY;
               end else begin
                  flash_d = flash_q - FW'(1);
               end
            end
         end
         default: begin
            if (!start_n_i) begin
               sx_d    = START_X_W;
               sy_d    = START_Y_W;
               lives_d = LIVES_INIT;
               flash_d = '0;
               state_d = ST_PLAY;
            end
         end
      endcase
   end

   maze_path_hit u_pix (.px_i(xe), .py_i(ye), .inside_o(pix_in), .goal_o(pix_goal));

   assign xe = {1'b0, x_i};
   assign ye = {1'b0, y_i};

   // In HIT the square blinks: visible while the remaining flash count is even.
   always_comb begin
      square_on = (xe >= {1'b0, sx_q}) && (xe <= {1'b0, sx_q} + SQ_M1) &&
                  (ye >= {1'b0, sy_q}) && (ye <= {1'b0, sy_q} + SQ_M1);
      show_sq   = square_on && ((state_q != ST_HIT) || !flash_q[0]);
      if (show_sq)       idx = (state_q == ST_HIT) ? IDX_FLASH : IDX_SQUARE;
      else if (pix_goal) idx = IDX_GOAL;
      else if (pix_in)   idx = IDX_PATH;
      else               idx = IDX_WALL;
      red_d   = idx[2] ? ONES : BG_R;
      green_d = idx[1] ? ONES : BG_G;
      blue_d  = idx[0] ? ONES : BG_B;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sx_q    <= START_X_W;
         sy_q    <= START_Y_W;
         lives_q <= LIVES_INIT;
         state_q <= ST_PLAY;
         flash_q <= '0;
         red_q   <= BG_R;
         green_q <= BG_G;
         blue_q  <= BG_B;
      end else begin
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         lives_q <= lives_d;
         state_q <= state_d;
         flash_q <= flash_d;
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
      end
   end

   assign red_o   = red_q;
   assign green_o = green_q;
   assign blue_o  = blue_q;
   assign lives_o = lives_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_maze_game_core.sv
module tb_maze_game_core;

   logic       clk = 1'b0;
   logic       reset_r = 1'b1;
   logic [9:0] x_r = 10'd700, y_r = 10'd10;
   logic       up_r = 1'b1, dn_r = 1'b1, rt_r = 1'b1, lf_r = 1'b1, st_r = 1'b1;
   logic [9:0] red, green, blue;
   logic [2:0] lives;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model of the game, in plain integers.
   int         m_sx, m_sy, m_lives, m_flash;
   logic [1:0] m_state;
   logic [29:0] exp_rgb;

   int RX0 [8] = '{40, 160, 160, 20, 20, 440, 560, 240};
   int RX1 [8] = '{200, 200, 400, 60, 120, 600, 600, 600};
   int RY0 [8] = '{47, 47, 260, 90, 200, 40, 80, 380};
   int RY1 [8] = '{90, 300, 300, 200, 240, 80, 420, 420};
   int PX_OFF [4] = '{0, 14, -1, 15};
   int PY_OFF [4] = '{0, 14, 0, 14};

   always #5 clk = ~clk;

   maze_game_core dut (
      .clk_i(clk), .reset_i(reset_r), .x_i(x_r), .y_i(y_r),
      .moveup_i(up_r), .movedown_i(dn_r), .moveright_i(rt_r), .moveleft_i(lf_r),
      .start_n_i(st_r), .red_o(red), .green_o(green), .blue_o(blue),
      .lives_o(lives), .state_o(state)
   );

   function automatic bit in_path(int px, int py);
      if (px < 0 || py < 0 || px >= 640 || py >= 480) return 0;
      for (int i = 0; i < 8; i++)
         if (px >= RX0[i] && px < RX1[i] && py >= RY0[i] && py < RY1[i]) return 1;
      return 0;
   endfunction

   function automatic bit in_goal(int px, int py);
      return px >= 360 && px < 400 && py >= 260 && py < 300;
   endfunction

   function automatic bit square_fits(int sx, int sy);
      return in_path(sx, sy) && in_path(sx + 14, sy) &&
             in_path(sx, sy + 14) && in_path(sx + 14, sy + 14);
   endfunction

   function automatic bit touches_goal(int sx, int sy);
      return sx <= 399 && sx + 14 >= 360 && sy <= 299 && sy + 14 >= 260;
   endfunction

   function automatic logic [29:0] model_rgb(int px, int py);
      int idx;
      bit sq;
      sq = px >= m_sx && px < m_sx + 15 && py >= m_sy && py < m_sy + 15;
      if (m_state == 2'd1 && (m_flash % 2) == 1) sq = 0;
      if (sq)                  idx = (m_state == 2'd1) ? 1 : 5;
      else if (in_goal(px, py)) idx = 2;
      else if (in_path(px, py)) idx = 7;
      else                      idx = 0;
      return {((idx & 4) != 0) ? 10'h3FF : 10'h0E1,
              ((idx & 2) != 0) ? 10'h3FF : 10'h2C2,
              ((idx & 1) != 0) ? 10'h3FF : 10'h37A};
   endfunction

   task automatic model_restart();
      m_sx = 55; m_sy = 55; m_lives = 3; m_flash = 0; m_state = 2'd0;
   endtask

   task automatic model_tick();
      int dx, dy;
      if (m_state == 2'd0) begin
         dx = 0; dy = 0;
         if (!up_r)      dy = -1;
         else if (!dn_r) dy = 1;
         else if (!rt_r) dx = 1;
         else if (!lf_r) dx = -1;
         else return;
         if (square_fits(m_sx + dx, m_sy + dy)) begin
            m_sx = m_sx + dx;
            m_sy = m_sy + dy;
            if (touches_goal(m_sx, m_sy)) m_state = 2'd2;
         end else begin
            if (m_lives > 0) m_lives = m_lives - 1;
            m_flash = 32;
            m_state = (m_lives == 0) ? 2'd3 : 2'd1;
         end
      end else if (m_state == 2'd1) begin
         m_flash = m_flash - 1;
         if (m_flash == 0) begin
            m_state = 2'd0; m_sx = 55; m_sy = 55;
         end
      end
   endtask

   // One clock: the model sees the same inputs the DUT samples at this edge.
   task automatic clk_cycle();
      @(posedge clk);
      if (reset_r) begin
         exp_rgb = {10'h0E1, 10'h2C2, 10'h37A};
         model_restart();
      end else begin
         exp_rgb = model_rgb(int'(x_r), int'(y_r));
         if ((m_state == 2'd2 || m_state == 2'd3) && !st_r) model_restart();
         else if (y_r == 10'd481 && x_r == 10'd0) model_tick();
      end
      #1;
   endtask

   task automatic do_tick(input logic [3:0] btn_n);
      {up_r, dn_r, rt_r, lf_r} = btn_n;
      x_r = 10'd0; y_r = 10'd481;
      clk_cycle();
      x_r = 10'd700; y_r = 10'd10;
   endtask

   task automatic probe(input int px, input int py);
      x_r = 10'(px); y_r = 10'(py);
      clk_cycle();
   endtask

   task automatic apply_reset();
      {up_r, dn_r, rt_r, lf_r} = 4'b1111;
      st_r = 1'b1;
      reset_r = 1'b1;
      clk_cycle();
      clk_cycle();
      reset_r = 1'b0;
   endtask

   task automatic test_reset();
      x_r = 10'd60; y_r = 10'd60;
      reset_r = 1'b1;
      clk_cycle();
      clk_cycle();
      n_checks++;
      if ({red, green, blue} !== {10'h0E1, 10'h2C2, 10'h37A}) begin
         n_fail++; $display("FAIL reset_rgb got %h want %h", {red, green, blue}, {10'h0E1, 10'h2C2, 10'h37A});
      end
      n_checks++;
      if (state !== 2'd0 || lives !== 3'd3) begin
         n_fail++; $display("FAIL reset_state got state %0d lives %0d want 0 3", state, lives);
      end
      reset_r = 1'b0;
      probe(60, 60);
      n_checks++;
      if ({red, green, blue} !== {10'h3FF, 10'h2C2, 10'h3FF}) begin
         n_fail++; $display("FAIL reset_square got %h want %h", {red, green, blue}, {10'h3FF, 10'h2C2, 10'h3FF});
      end
   endtask

   task automatic test_move_right();
      apply_reset();
      for (int t = 0; t < 10; t++) begin
         do_tick(4'b1101);
         for (int c = 0; c < 2; c++) begin
            probe(m_sx, m_sy);
            n_checks++;
            if (state !== m_state || lives !== 3'(m_lives) || {red, green, blue} !== exp_rgb) begin
               n_fail++; $display("FAIL move_right t%0d got st %0d lv %0d rgb %h want st %0d lv %0d rgb %h",
                                  t, state, lives, {red, green, blue}, m_state, m_lives, exp_rgb);
            end
         end
      end
      probe(65, 55);
      n_checks++;
      if ({red, green, blue} !== {10'h3FF, 10'h2C2, 10'h3FF}) begin
         n_fail++; $display("FAIL move_right_at65 got %h want %h", {red, green, blue}, {10'h3FF, 10'h2C2, 10'h3FF});
      end
      probe(64, 55);
      n_checks++;
      if ({red, green, blue} !== {10'h3FF, 10'h3FF, 10'h3FF}) begin
         n_fail++; $display("FAIL move_right_left_of_sq got %h want %h", {red, green, blue}, {10'h3FF, 10'h3FF, 10'h3FF});
      end
   endtask

   task automatic test_moveup_hit();
      apply_reset();
      for (int t = 0; t < 9; t++) do_tick(4'b0111);
      n_checks++;
      if (state !== 2'd1 || lives !== 3'd2 || m_sy != 47) begin
         n_fail++; $display("FAIL moveup_hit got st %0d lv %0d want 1 2 (model y %0d)", state, lives, m_sy);
      end
      for (int t = 0; t < 32; t++) begin
         do_tick(4'b0000);
         probe(55, 47);
         n_checks++;
         if (state !== m_state || {red, green, blue} !== exp_rgb) begin
            n_fail++; $display("FAIL hit_flash t%0d got st %0d rgb %h want st %0d rgb %h",
                               t, state, {red, green, blue}, m_state, exp_rgb);
         end
      end
      n_checks++;
      if (state !== 2'd0 || lives !== 3'd2) begin
         n_fail++; $display("FAIL hit_recover got st %0d lv %0d want 0 2", state, lives);
      end
      for (int p = 0; p < 4; p++) begin
         probe(55 + PX_OFF[p], 55 + PY_OFF[p]);
         n_checks++;
         if ({red, green, blue} !== exp_rgb) begin
            n_fail++; $display("FAIL respawn_probe%0d got %h want %h", p, {red, green, blue}, exp_rgb);
         end
      end
   endtask

   task automatic test_lose_restart();
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 9; t++) do_tick(4'b0111);
         n_checks++;
         if (state !== m_state || lives !== 3'(m_lives)) begin
            n_fail++; $display("FAIL lose_collide%0d got st %0d lv %0d want st %0d lv %0d",
                               k, state, lives, m_state, m_lives);
         end
         if (k < 2) for (int t = 0; t < 32; t++) do_tick(4'b0000);
      end
      n_checks++;
      if (state !== 2'd3 || lives !== 3'd0) begin
         n_fail++; $display("FAIL lose_state got st %0d lv %0d want 3 0", state, lives);
      end
      for (int t = 0; t < 3; t++) do_tick(4'b0000);
      n_checks++;
      if (state !== 2'd3 || lives !== 3'd0) begin
         n_fail++; $display("FAIL lose_frozen got st %0d lv %0d want 3 0", state, lives);
      end
      {up_r, dn_r, rt_r, lf_r} = 4'b1111;
      st_r = 1'b0;
      probe(300, 300);
      st_r = 1'b1;
      n_checks++;
      if (state !== 2'd0 || lives !== 3'd3) begin
         n_fail++; $display("FAIL lose_restart got st %0d lv %0d want 0 3", state, lives);
      end
      probe(55, 55);
      n_checks++;
      if ({red, green, blue} !== {10'h3FF, 10'h2C2, 10'h3FF}) begin
         n_fail++; $display("FAIL lose_restart_pos got %h want %h", {red, green, blue}, {10'h3FF, 10'h2C2, 10'h3FF});
      end
   endtask

   task automatic test_win();
      int early;
      apply_reset();
      early = 0;
      for (int k = 0; k < 200 && m_sx < 170; k++) do_tick(4'b1101);
      for (int k = 0; k < 300 && m_sy < 285; k++) do_tick(4'b1011);
      for (int k = 0; k < 250 && m_state == 2'd0; k++) begin
         do_tick(4'b1101);
         if (m_state == 2'd0 && state !== 2'd0) early++;
      end
      n_checks++;
      if (state !== 2'd2 || early != 0) begin
         n_fail++; $display("FAIL win_reach got st %0d want 2 (early %0d)", state, early);
      end
      for (int t = 0; t < 4; t++) do_tick(4'(t * 5));
      for (int p = 0; p < 4; p++) begin
         probe(m_sx + PX_OFF[p], m_sy + PY_OFF[p]);
         n_checks++;
         if (state !== 2'd2 || {red, green, blue} !== exp_rgb) begin
            n_fail++; $display("FAIL win_frozen%0d got st %0d rgb %h want 2 rgb %h",
                               p, state, {red, green, blue}, exp_rgb);
         end
      end
      st_r = 1'b0;
      probe(10, 10);
      st_r = 1'b1;
      n_checks++;
      if (state !== 2'd0 || lives !== 3'd3) begin
         n_fail++; $display("FAIL win_restart got st %0d lv %0d want 0 3", state, lives);
      end
   endtask

   task automatic test_reset_mid_hit();
      apply_reset();
      for (int t = 0; t < 9; t++) do_tick(4'b0111);
      for (int t = 0; t < 22; t++) do_tick(4'b1111);
      n_checks++;
      if (state !== 2'd1 || m_flash != 10) begin
         n_fail++; $display("FAIL midhit_pre got st %0d want 1 (model flash %0d)", state, m_flash);
      end
      reset_r = 1'b1;
      clk_cycle();
      reset_r = 1'b0;
      n_checks++;
      if (state !== 2'd0 || lives !== 3'd3) begin
         n_fail++; $display("FAIL midhit_reset got st %0d lv %0d want 0 3", state, lives);
      end
      do_tick(4'b0101);
      probe(55, 54);
      n_checks++;
      if ({red, green, blue} !== {10'h3FF, 10'h2C2, 10'h3FF}) begin
         n_fail++; $display("FAIL priority_up got %h want %h", {red, green, blue}, {10'h3FF, 10'h2C2, 10'h3FF});
      end
      probe(70, 54);
      n_checks++;
      if ({red, green, blue} !== {10'h3FF, 10'h3FF, 10'h3FF}) begin
         n_fail++; $display("FAIL priority_noright got %h want %h", {red, green, blue}, {10'h3FF, 10'h3FF, 10'h3FF});
      end
   endtask

   task automatic test_random();
      logic [3:0] btn;
      apply_reset();
      for (int it = 0; it < 400; it++) begin
         btn = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) btn = 4'b1111;
         do_tick(btn);
         probe(m_sx + int'($urandom_range(0, 18)) - 2, m_sy + int'($urandom_range(0, 18)) - 2);
         n_checks++;
         if (state !== m_state || lives !== 3'(m_lives) || {red, green, blue} !== exp_rgb) begin
            n_fail++; $display("FAIL random_near it%0d got st %0d lv %0d rgb %h want st %0d lv %0d rgb %h",
                               it, state, lives, {red, green, blue}, m_state, m_lives, exp_rgb);
         end
         probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
         n_checks++;
         if ({red, green, blue} !== exp_rgb) begin
            n_fail++; $display("FAIL random_pix it%0d got %h want %h", it, {red, green, blue}, exp_rgb);
         end
         if ($urandom_range(0, 9) == 0) begin
            st_r = 1'b0;
            probe(700, 10);
            st_r = 1'b1;
            n_checks++;
            if (state !== m_state || lives !== 3'(m_lives)) begin
               n_fail++; $display("FAIL random_start it%0d got st %0d lv %0d want st %0d lv %0d",
                                  it, state, lives, m_state, m_lives);
            end
         end
      end
   endtask

   initial begin
      model_restart();
      exp_rgb = '0;
      test_reset();
      test_move_right();
      test_moveup_hit();
      test_lose_restart();
      test_win();
      test_reset_mid_hit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
